// File: rtl/umi_skid_buffer_pkg.sv
// Shared UMI definitions: buffer state encoding used by the skid buffer
// and by anything that inspects its occupancy.
package umi_skid_buffer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/umi_skid_buffer.sv
// Two-entry UMI skid buffer: fully registered forward and backward paths,
// one transaction per cycle at full throughput, order preserving.
module umi_skid_buffer
  import umi_skid_buffer_pkg::*;
#(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          umi_in_valid,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready,
  output logic [1:0]    occupancy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and ready here is a flop only.
  localparam int PW = CW + 2 * AW + DW;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic [PW-1:0]   in_payload;
  logic            in_fire;
  logic            out_fire;

  assign in_payload = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = umi_in_valid & in_ready_q;
    out_fire = (state_q != ST_EMPTY) & umi_out_ready;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_payload;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        case ({in_fire, out_fire})
          2'b10: begin
            skid_d  = in_payload;
            state_d = ST_FULL;
          end
          2'b01: state_d = ST_EMPTY;
          2'b11: main_d = in_payload;
          default: ;
        endcase
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain of main can happen
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign umi_in_ready  = in_ready_q;
  assign umi_out_valid = (state_q != ST_EMPTY);
  assign occupancy     = state_q;
  assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = main_q;

endmodule

// File: tb/tb_umi_skid_buffer.sv
// Randomized bench for umi_skid_buffer against a queue-based reference model.
module tb_umi_skid_buffer;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 128;
  localparam int PW = CW + 2 * AW + DW;

  logic          clk;
  logic          reset;
  logic          umi_in_valid;
  logic [CW-1:0] umi_in_cmd;
  logic [AW-1:0] umi_in_dstaddr;
  logic [AW-1:0] umi_in_srcaddr;
  logic [DW-1:0] umi_in_data;
  logic          umi_in_ready;
  logic          umi_out_valid;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic          umi_out_ready;
  logic [1:0]    occupancy;

  umi_skid_buffer #(.CW(CW), .AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .occupancy       (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: accepted-but-not-delivered transactions, oldest first
  logic [PW-1:0] exp_q[$];
  logic          released;
  logic          prev_stall;
  int            n_vec;
  int            n_err;
  int            out_fires;

  function automatic logic [PW-1:0] out_pl();
    return {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
  endfunction

  function automatic logic [PW-1:0] rand_pl();
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic logic [PW-1:0] mk_pl(input logic [CW-1:0] c, input logic [AW-1:0] d,
                                          input logic [AW-1:0] s, input logic [DW-1:0] x);
    return {c, d, s, x};
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called #1 after a rising edge: check outputs, drive inputs, advance one edge.
  task automatic cycle(input logic v, input logic r, input logic [PW-1:0] pl, output logic acc);
    logic exp_rdy;
    logic of;
    umi_in_valid  = v;
    {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data} = pl;
    umi_out_ready = r;
    exp_rdy = released && (exp_q.size() < 2);
    chk("in_ready", PW'(umi_in_ready), PW'(exp_rdy));
    chk("out_valid", PW'(umi_out_valid), PW'(exp_q.size() > 0));
    chk("occupancy", PW'(occupancy), PW'(exp_q.size()));
    if (exp_q.size() > 0) chk(prev_stall ? "stall_payload" : "payload", out_pl(), exp_q[0]);
    acc = v & exp_rdy;
    of  = (exp_q.size() > 0) & r;
    prev_stall = (exp_q.size() > 0) & ~r;
    if (of) out_fires++;
    @(posedge clk);
    #1;
    released = 1'b1;
    if (of) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(pl);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    exp_q.delete();
    released   = 1'b0;
    prev_stall = 1'b0;
  endtask

  logic          acc;
  logic [PW-1:0] p;
  int            accepted;
  int            guard;

  initial begin
    n_vec = 0; n_err = 0; out_fires = 0;
    released = 1'b0; prev_stall = 1'b0;
    reset = 1'b1;
    umi_in_valid = 1'b0; umi_out_ready = 1'b0;
    {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", PW'(umi_in_ready), '0);
    chk("rst_out_valid", PW'(umi_out_valid), '0);
    chk("rst_occupancy", PW'(occupancy), '0);
    chk("rst_payload", out_pl(), '0);
    reset = 1'b0;
    // first cycle after release still expects in_ready=0
    cycle(1'b0, 1'b0, '0, acc);
    cycle(1'b0, 1'b0, '0, acc);

    // single write, latency and payload
    p = mk_pl(32'h3, 64'h100, 64'h0, 128'hAA);
    cycle(1'b1, 1'b1, p, acc);
    chk("single_acc", PW'(acc), PW'(1));
    cycle(1'b0, 1'b1, '0, acc);
    cycle(1'b0, 1'b1, '0, acc);

    // 100 back-to-back, full throughput
    out_fires = 0;
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, mk_pl(32'h1, 64'h200, 64'h300, DW'(i)), acc);
    cycle(1'b0, 1'b1, '0, acc);
    chk("b2b_fires", PW'(out_fires), PW'(100));

    // stall: third offer is refused until the buffer drains
    cycle(1'b1, 1'b0, mk_pl(32'h5, 64'h0, 64'h0, 128'd1), acc);
    cycle(1'b1, 1'b0, mk_pl(32'h5, 64'h0, 64'h0, 128'd2), acc);
    cycle(1'b1, 1'b0, mk_pl(32'h5, 64'h0, 64'h0, 128'd3), acc);
    cycle(1'b1, 1'b0, mk_pl(32'h5, 64'h0, 64'h0, 128'd3), acc);
    guard = 0;
    do begin
      cycle(1'b1, 1'b1, mk_pl(32'h5, 64'h0, 64'h0, 128'd3), acc);
      guard++;
    end while (!acc && guard < 10);
    if (!acc) chk("stall_offer_timeout", PW'(acc), PW'(1));
    repeat (4) cycle(1'b0, 1'b1, '0, acc);

    // random valid/ready
    accepted = 0;
    guard = 0;
    while (accepted < 10000 && guard < 60000) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_pl(), acc);
      if (acc) accepted++;
      guard++;
    end
    if (accepted < 10000) chk("random_timeout", PW'(accepted), PW'(10000));
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      cycle(1'b0, 1'b1, '0, acc);
      guard++;
    end

    // asynchronous reset while FULL
    cycle(1'b1, 1'b0, rand_pl(), acc);
    cycle(1'b1, 1'b0, rand_pl(), acc);
    chk("full_occ", PW'(occupancy), PW'(2));
    #2;
    do_reset();
    chk("async_out_valid", PW'(umi_out_valid), '0);
    chk("async_occupancy", PW'(occupancy), '0);
    chk("async_in_ready", PW'(umi_in_ready), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) cycle(1'b0, 1'b1, '0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/umi_skid_buffer.md
UMI_SKID_BUFFER -- requirements
Module: umi_skid_buffer

Interface
REQ-001: Parameter CW, default 32, UMI command width.
REQ-002: Parameter AW, default 64, UMI address width.
REQ-003: Parameter DW, default 128, UMI data width.
REQ-004: clk  input  1  single clock; all state changes on its rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: umi_in_valid  input  1  upstream transaction valid.
REQ-007: umi_in_cmd / umi_in_dstaddr / umi_in_srcaddr / umi_in_data  input  CW/AW/AW/DW  upstream payload.
REQ-008: umi_in_ready  output  1  buffer can accept a transaction.
REQ-009: umi_out_valid  output  1  downstream transaction valid.
REQ-010: umi_out_cmd / umi_out_dstaddr / umi_out_srcaddr / umi_out_data  output  CW/AW/AW/DW  downstream payload.
REQ-011: umi_out_ready  input  1  downstream (e.g. umi_fifo input) accepts.
REQ-012: occupancy  output  2  entries held (0, 1 or 2).

Function
REQ-013: Input fire = umi_in_valid & umi_in_ready; output fire = umi_out_valid & umi_out_ready.
REQ-014: The buffer SHALL hold a main register (drives umi_out_*) and a skid register, tracked by state EMPTY (0), BUSY (1) or FULL (2).
REQ-015: EMPTY: input fire -> main <= input, go BUSY; otherwise stay.
REQ-016: BUSY, input fire only -> skid <= input, go FULL.
REQ-017: BUSY, output fire only -> go EMPTY.
REQ-018: BUSY, simultaneous input and output fire -> main <= input, stay BUSY.
REQ-019: BUSY, no fire -> hold.
REQ-020: FULL: output fire -> main <= skid, go BUSY; no input fire can occur in FULL.
REQ-021: umi_out_valid SHALL be 1 exactly when state is BUSY or FULL.
REQ-022: umi_in_ready SHALL be a registered signal, equal to 1 exactly when state is not FULL and reset has been released for at least one edge; no combinational path from umi_out_ready to umi_in_ready.
REQ-023: No combinational path from any umi_in_* to any umi_out_*; latency from input fire to umi_out_valid is exactly 1 cycle.
REQ-024: Sustained throughput of one transaction per cycle when umi_out_ready is held 1.
REQ-025: While umi_out_valid=1 and umi_out_ready=0, umi_out_* payload SHALL remain stable.
REQ-026: Transactions SHALL exit in acceptance order with no loss, duplication or payload-field mixing.
REQ-027: occupancy SHALL equal the state encoding (EMPTY=0, BUSY=1, FULL=2); value 3 never appears.

Reset
REQ-028: While reset=1: state EMPTY, umi_in_ready=0, umi_out_valid=0, occupancy=0, all umi_out_* payload and skid register = 0.
REQ-029: umi_in_ready SHALL rise to 1 on the first rising clk edge after reset deasserts.
REQ-030: Reset asserted mid-operation SHALL discard all held transactions immediately (asynchronously), with no output fire reported afterwards for them.

Structure
REQ-031: The state encoding enum (EMPTY, BUSY, FULL) SHALL live in the shared UMI package; CW/AW/DW remain module parameters.
REQ-032: No sub-module is required; payload storage and mux are internal, with one payload bundle per register.

Verification
REQ-033: Reset release, no stimulus -> umi_in_ready 0 then 1 one edge after release; umi_out_valid 0, occupancy 0.
REQ-034: Single write cmd=0x00000003, dstaddr=0x100, data=0xAA, umi_out_ready=1 -> umi_out_valid high exactly one cycle later with identical payload; occupancy 1 then 0.
REQ-035: 100 back-to-back transactions with incrementing data 0..99, umi_out_ready=1 -> 100 output fires in 100 consecutive cycles, data 0..99 in order.
REQ-036: Stall: umi_out_ready=0, offer 3 transactions (data 1,2,3) -> 2 accepted, umi_in_ready=0, occupancy=2, output stable at data 1; release ready -> outputs 1,2,3 in order.
REQ-037: Random valid/ready (50% each), 10000 transactions against a reference queue -> zero mismatches and no payload change while stalled.
REQ-038: Assert reset while FULL -> umi_out_valid and occupancy go 0 without a clock edge; after release, no stale transaction appears.
